// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared FSM state encoding, ALU control codes and nibble-write helper
package alu_seq_pkg;

    // Sequencer phases, 3-bit encoding
    typedef enum logic [2:0] {
        EDIT_A = 3'd0,
        EDIT_B = 3'd1,
        EXEC   = 3'd2,
        WAIT   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    // Control codes understood by the aluc/alu pair
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Replace one nibble of v: sw[5:4] selects the nibble, sw[3:0] is the new value
    function automatic logic [15:0] nib_write(input logic [15:0] v, input logic [5:0] sw);
        logic [15:0] r;
        r = v;
        r[{sw[5:4], 2'b00} +: 4] = sw[3:0];
        return r;
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// rtl/btn_pulse.sv - button synchronizer, debounce counter and one-cycle rising-edge pulse
module btn_pulse #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the raw, asynchronous button input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive samples that differ from the current one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Delayed debounced level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - front-panel ALU sequencer top; ALU_SEQ_CHAIN_EN enables result chaining from SHOW
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int          DB_CYCLES = 16,
    parameter int          ALU_LAT   = 1,
    parameter logic [15:0] OP1_INIT  = 16'h1122,
    parameter logic [15:0] OP2_INIT  = 16'h3344
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  button,
    input  logic [5:0]  switch,
    input  logic [15:0] alu_res,
    input  logic        alu_zf,
    output logic [15:0] op1,
    output logic [15:0] op2,
    output logic [2:0]  control,
    output logic [15:0] disp_num,
    output logic        o_zf,
    output logic        busy,
    output logic        done
);

    localparam int            WW        = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [WW-1:0] WAIT_INIT = WW'(ALU_LAT - 1);

    state_t          state;
    state_t          state_next;
    logic            p0;
    logic            p1;
    logic [15:0]     result;
    logic [WW-1:0]   wait_cnt;
    logic            wr_a;
    logic            wr_b;
    logic            ld_ctrl;
    logic            ld_wait;
    logic            cnt_dec;
    logic            capture;
    logic            chain;

    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_btn0 (
        .clk   (clk),
        .rst   (rst),
        .btn   (button[0]),
        .pulse (p0)
    );

    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_btn1 (
        .clk   (clk),
        .rst   (rst),
        .btn   (button[1]),
        .pulse (p1)
    );

    // State register; reset discards any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EDIT_A;
        end else begin
            state <= state_next;
        end
    end

    // Next state, datapath strobes and phase-dependent outputs; advance beats write
    always_comb begin
        state_next = state;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        ld_ctrl    = 1'b0;
        ld_wait    = 1'b0;
        cnt_dec    = 1'b0;
        capture    = 1'b0;
        chain      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        disp_num   = op1;
        case (state)
            EDIT_A: begin
                disp_num = op1;
                if (p1) begin
                    state_next = EDIT_B;
                end else if (p0) begin
                    wr_a = 1'b1;
                end
            end
            EDIT_B: begin
                disp_num = op2;
                if (p1) begin
                    ld_ctrl    = 1'b1;
                    state_next = EXEC;
                end else if (p0) begin
                    wr_b = 1'b1;
                end
            end
            EXEC: begin
                busy       = 1'b1;
                disp_num   = op2;
                ld_wait    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy     = 1'b1;
                disp_num = op2;
                if (wait_cnt == '0) begin
                    capture    = 1'b1;
                    done       = 1'b1;
                    state_next = SHOW;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SHOW: begin
                disp_num = result;
                if (p1) begin
                    state_next = EDIT_A;
                end else if (p0) begin
`ifdef ALU_SEQ_CHAIN_EN
                    chain      = 1'b1;
                    state_next = EDIT_B;
`endif
                end
            end
            default: begin
                state_next = EDIT_A;
            end
        endcase
    end

    // Operand, control, result and flag registers; held stable while the ALU works
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1     <= OP1_INIT;
            op2     <= OP2_INIT;
            control <= ALU_AND;
            result  <= '0;
            o_zf    <= 1'b0;
        end else begin
            if (wr_a) begin
                op1 <= nib_write(op1, switch);
            end else if (chain) begin
                op1 <= result;
            end
            if (wr_b) begin
                op2 <= nib_write(op2, switch);
            end
            if (ld_ctrl) begin
                control <= switch[2:0];
            end
            if (capture) begin
                result <= alu_res;
                o_zf   <= alu_zf;
            end
        end
    end

    // ALU latency countdown, loaded on EXEC and run down in WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (ld_wait) begin
            wait_cnt <= WAIT_INIT;
        end else if (cnt_dec) begin
            wait_cnt <= wait_cnt - WW'(1);
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl with vector table and random reference model
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int DB  = 4;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  button;
    logic [5:0]  switch;
    logic [15:0] alu_res;
    logic        alu_zf;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  control;
    logic [15:0] disp_num;
    logic        o_zf;
    logic        busy;
    logic        done;

    int n_pass   = 0;
    int n_total  = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    // Reference model of the panel: phase 0=EDIT_A, 1=EDIT_B, 3=SHOW
    logic [15:0] m_op1;
    logic [15:0] m_op2;
    logic [15:0] m_res;
    logic [2:0]  m_ctrl;
    logic        m_zf;
    int          m_phase;

    typedef struct {
        logic [1:0]  btn;
        logic [5:0]  sw;
        logic [15:0] e_op1;
        logic [15:0] e_op2;
        logic [2:0]  e_ctrl;
        logic [15:0] e_disp;
        logic        e_zf;
    } vec_t;

    vec_t vt[8];

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_XOR: return a ^ b;
            ALU_NOR: return ~(a | b);
            ALU_SUB: return a - b;
            ALU_SLT: return {15'd0, ($signed(a) < $signed(b))};
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_res = ref_alu(op1, op2, control);
    assign alu_zf  = (alu_res == 16'h0000);

    alu_seq_ctrl #(
        .DB_CYCLES (DB),
        .ALU_LAT   (LAT),
        .OP1_INIT  (16'h1122),
        .OP2_INIT  (16'h3344)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .button   (button),
        .switch   (switch),
        .alu_res  (alu_res),
        .alu_zf   (alu_zf),
        .op1      (op1),
        .op2      (op2),
        .control  (control),
        .disp_num (disp_num),
        .o_zf     (o_zf),
        .busy     (busy),
        .done     (done)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_op1 = 16'h1122; m_op2 = 16'h3344; m_res = 16'h0; m_ctrl = 3'd0; m_zf = 1'b0; m_phase = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; button = 2'b00; switch = 6'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] b, input logic [5:0] s);
        @(negedge clk);
        switch = s; button = b;
        repeat (DB + 10) @(negedge clk);
        button = 2'b00;
        repeat (DB + 8) @(negedge clk);
    endtask

    // Apply one accepted press to the model; ran reports that an ALU operation was launched
    task automatic model_step(input logic [1:0] b, input logic [5:0] s, output bit ran);
        ran = 1'b0;
        case (m_phase)
            0: if (b[1]) m_phase = 1; else if (b[0]) m_op1[4*s[5:4] +: 4] = s[3:0];
            1: if (b[1]) begin
                   m_ctrl = s[2:0];
                   m_res = ref_alu(m_op1, m_op2, m_ctrl);
                   m_zf = (m_res == 16'h0);
                   m_phase = 3; ran = 1'b1;
               end else if (b[0]) m_op2[4*s[5:4] +: 4] = s[3:0];
            default: if (b[1]) m_phase = 0;
`ifdef ALU_SEQ_CHAIN_EN
                else if (b[0]) begin m_op1 = m_res; m_phase = 1; end
`endif
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e_disp;
        e_disp = (m_phase == 0) ? m_op1 : (m_phase == 1) ? m_op2 : m_res;
        chk({tag, ".op1"}, op1, m_op1);
        chk({tag, ".op2"}, op2, m_op2);
        chk({tag, ".ctrl"}, control, m_ctrl);
        chk({tag, ".disp"}, disp_num, e_disp);
        chk({tag, ".zf"}, o_zf, m_zf);
        chk({tag, ".busy"}, busy, 1'b0);
    endtask

    task automatic mpress(input string tag, input logic [1:0] b, input logic [5:0] s);
        int b0, d0;
        bit ran;
        b0 = busy_cnt; d0 = done_cnt;
        model_step(b, s, ran);
        press(b, s);
        check_all(tag);
        chk({tag, ".done_n"}, done_cnt - d0, ran ? 1 : 0);
        chk({tag, ".busy_n"}, busy_cnt - b0, ran ? LAT + 1 : 0);
    endtask

    initial begin
        bit seen;
        vt[0] = '{2'b01, 6'b11_0101, 16'h5122, 16'h3344, 3'd0, 16'h5122, 1'b0};
        vt[1] = '{2'b01, 6'b00_1010, 16'h512A, 16'h3344, 3'd0, 16'h512A, 1'b0};
        vt[2] = '{2'b11, 6'b01_1111, 16'h512A, 16'h3344, 3'd0, 16'h3344, 1'b0};
        vt[3] = '{2'b01, 6'b00_0000, 16'h512A, 16'h3340, 3'd0, 16'h3340, 1'b0};
        vt[4] = '{2'b01, 6'b10_0111, 16'h512A, 16'h3740, 3'd0, 16'h3740, 1'b0};
        vt[5] = '{2'b10, 6'b00_0010, 16'h512A, 16'h3740, 3'd2, 16'h886A, 1'b0};
`ifdef ALU_SEQ_CHAIN_EN
        vt[6] = '{2'b01, 6'b00_0000, 16'h886A, 16'h3740, 3'd2, 16'h3740, 1'b0};
        vt[7] = '{2'b10, 6'b00_0010, 16'h886A, 16'h3740, 3'd2, 16'hBFAA, 1'b0};
`else
        vt[6] = '{2'b01, 6'b00_0000, 16'h512A, 16'h3740, 3'd2, 16'h886A, 1'b0};
        vt[7] = '{2'b10, 6'b00_0010, 16'h512A, 16'h3740, 3'd2, 16'h512A, 1'b0};
`endif

        // Reset state, then reset asserted while an operation is in flight
        do_reset();
        check_all("rst0");
        chk("rst0.done", done, 1'b0);
        mpress("to_b", 2'b10, 6'd0);
        @(negedge clk);
        switch = {3'd0, ALU_ADD}; button = 2'b10;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk("rst_mid.busy_seen", seen, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid.disp", disp_num, 16'h1122);
        chk("rst_mid.op1", op1, 16'h1122);
        chk("rst_mid.op2", op2, 16'h3344);
        chk("rst_mid.busy", busy, 1'b0);
        chk("rst_mid.done", done, 1'b0);
        chk("rst_mid.ctrl", control, 3'd0);
        button = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Glitch shorter than the debounce window is ignored; a real press writes once after the latency
        do_reset();
        @(negedge clk);
        switch = 6'b11_0101; button = 2'b01;
        repeat (2) @(negedge clk);
        button = 2'b00;
        repeat (12) @(negedge clk);
        chk("glitch.op1", op1, 16'h1122);
        @(negedge clk);
        button = 2'b01;
        for (int k = 1; k <= DB + 3; k++) begin
            @(negedge clk);
            if (k == DB + 1) chk("lat.early", op1, 16'h1122);
            if (k == DB + 3) chk("lat.write", op1, 16'h5122);
        end
        switch = 6'b11_1111;
        repeat (10) @(negedge clk);
        chk("lat.single", op1, 16'h5122);
        button = 2'b00;
        repeat (10) @(negedge clk);

        // Directed vector table from reset values
        do_reset();
        for (int i = 0; i < 8; i++) begin
            press(vt[i].btn, vt[i].sw);
            chk($sformatf("vec%0d.op1", i), op1, vt[i].e_op1);
            chk($sformatf("vec%0d.op2", i), op2, vt[i].e_op2);
            chk($sformatf("vec%0d.ctrl", i), control, vt[i].e_ctrl);
            chk($sformatf("vec%0d.disp", i), disp_num, vt[i].e_disp);
            chk($sformatf("vec%0d.zf", i), o_zf, vt[i].e_zf);
        end

        // Zero flag: subtract equal operands, then a nonzero result clears it
        do_reset();
        mpress("z.a0", 2'b01, {2'd0, 4'h4});
        mpress("z.a1", 2'b01, {2'd1, 4'h4});
        mpress("z.a2", 2'b01, {2'd2, 4'h3});
        mpress("z.a3", 2'b01, {2'd3, 4'h3});
        mpress("z.adv", 2'b10, 6'd0);
        mpress("z.sub", 2'b10, {3'd0, ALU_SUB});
        chk("z.sub.zf1", o_zf, 1'b1);
        chk("z.sub.res0", disp_num, 16'h0000);
        mpress("z.toa", 2'b10, 6'd0);
        mpress("z.tob", 2'b10, 6'd0);
        mpress("z.or", 2'b10, {3'd0, ALU_OR});
        chk("z.or.zf0", o_zf, 1'b0);

        // Both buttons together: advance wins and the write is dropped
        mpress("both.toa", 2'b10, 6'd0);
        mpress("both", 2'b11, 6'b01_1111);
        chk("both.op1", op1, 16'h3344);

        // Presses whose pulse lands in EXEC (off=1) or WAIT (off=2) are dropped
        for (int off = 1; off <= 2; off++) begin
            int d0;
            bit ran;
            d0 = done_cnt;
            model_step(2'b10, {3'b111, ALU_XOR}, ran);
            @(negedge clk);
            switch = {3'b111, ALU_XOR}; button = 2'b10;
            repeat (off) @(negedge clk);
            button = 2'b11;
            repeat (14) @(negedge clk);
            button = 2'b00;
            repeat (12) @(negedge clk);
            check_all($sformatf("drop%0d", off));
            chk($sformatf("drop%0d.done_n", off), done_cnt - d0, 1);
            mpress("drop.toa", 2'b10, 6'd0);
            mpress("drop.tob", 2'b10, 6'd0);
        end

        // Random presses against the model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] b;
            logic [5:0] s;
            b = 2'($urandom_range(1, 3));
            s = 6'($urandom);
            mpress($sformatf("rnd%0d", i), b, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
